// File: rtl/axis_out_pkg.sv
// Shared definitions for the AXI-Stream output downsizer.
// Default geometry, sub-beat index width helper and the accumulator word type.
package axis_out_pkg;

  localparam int unsigned WORD_WIDTH_DEF = 32;
  localparam int unsigned S_WORDS_DEF    = 8;
  localparam int unsigned M_WORDS_DEF    = 2;
  localparam int unsigned RATIO          = S_WORDS_DEF / M_WORDS_DEF;
  localparam int unsigned IDX_W          = $clog2(RATIO);

  typedef logic [WORD_WIDTH_DEF-1:0] word_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Index width for a given number of sub-beats, never below one bit.
  function automatic int unsigned idx_w_of(input int unsigned ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/axis_out_slice_mux.sv
// Selects one narrow sub-beat (data and keep) out of the held wide beat.
module axis_out_slice_mux
  import axis_out_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int unsigned S_WORDS    = S_WORDS_DEF,
  parameter int unsigned M_WORDS    = M_WORDS_DEF,
  parameter int unsigned SEL_W      = IDX_W
) (
  input  logic [S_WORDS*WORD_WIDTH-1:0] hold_data,
  input  logic [S_WORDS-1:0]            hold_keep,
  input  logic [SEL_W-1:0]              idx,
  output logic [M_WORDS*WORD_WIDTH-1:0] tdata_c,
  output logic [M_WORDS-1:0]            tkeep_c
);

  localparam int unsigned N_SUB = S_WORDS / M_WORDS;
  localparam int unsigned SUB_W = M_WORDS * WORD_WIDTH;

  // Constant-slice decode keeps the selector free of variable part-selects.
  always_comb begin
    tdata_c = '0;
    tkeep_c = '0;
    for (int unsigned i = 0; i < N_SUB; i++) begin
      if (idx == SEL_W'(i)) begin
        tdata_c = hold_data[i*SUB_W +: SUB_W];
        tkeep_c = hold_keep[i*M_WORDS +: M_WORDS];
      end
    end
  end

endmodule

// File: rtl/axis_out_downsizer.sv
// Wide-to-narrow AXI-Stream downsizer on the accelerator output path.
// Holds one wide beat and replays it lowest word first as S_WORDS/M_WORDS
// narrow beats; a new wide beat may load as the final sub-beat leaves.
// Optional build macro AXIS_OUT_DOWNSIZER_SKIP_NULL_EN: trailing sub-beats
// with no keep bits set are not emitted and tlast moves to the last live one.
module axis_out_downsizer
  import axis_out_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int unsigned S_WORDS    = S_WORDS_DEF,
  parameter int unsigned M_WORDS    = M_WORDS_DEF
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [S_WORDS*WORD_WIDTH-1:0] s_axis_tdata,
  input  logic [S_WORDS-1:0]            s_axis_tkeep,
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [M_WORDS*WORD_WIDTH-1:0] m_axis_tdata,
  output logic [M_WORDS-1:0]            m_axis_tkeep,
  output logic                          m_axis_tlast
);

  localparam int unsigned N_SUB  = S_WORDS / M_WORDS;
  localparam int unsigned SEL_W  = idx_w_of(N_SUB);
  localparam int unsigned DATA_W = S_WORDS * WORD_WIDTH;
  localparam logic [SEL_W-1:0] TOP_IDX = SEL_W'(N_SUB - 1);

  // Geometry must split evenly into at least two sub-beats.
  if (((S_WORDS % M_WORDS) != 0) || (N_SUB < 2)) begin : g_bad_cfg
    $error("axis_out_downsizer: S_WORDS must be a multiple of M_WORDS with ratio >= 2");
  end

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [S_WORDS-1:0] keep_q, keep_d;
  logic               last_q, last_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [SEL_W-1:0]   last_idx_c;
  logic               at_last_c;
  logic               m_hs_c;
  logic               s_ready_c;
  logic               s_hs_c;
  logic               load_c;

`ifdef AXIS_OUT_DOWNSIZER_SKIP_NULL_EN
  logic [SEL_W-1:0] last_idx_q, last_idx_d;
  logic [SEL_W-1:0] load_last_idx_c;
  logic             load_any_c;

  // Highest sub-beat of the incoming beat that carries any keep bit.
  always_comb begin
    load_last_idx_c = '0;
    load_any_c      = 1'b0;
    for (int unsigned i = 0; i < N_SUB; i++) begin
      if (|s_axis_tkeep[i*M_WORDS +: M_WORDS]) begin
        load_last_idx_c = SEL_W'(i);
        load_any_c      = 1'b1;
      end
    end
  end

  assign last_idx_c = last_idx_q;
`else
  assign last_idx_c = TOP_IDX;
`endif

  assign at_last_c = (idx_q == last_idx_c);
  assign m_hs_c    = (state_q == ST_FULL) && m_axis_tready;
  assign s_ready_c = !areset && ((state_q == ST_EMPTY) || (m_hs_c && at_last_c));
  assign s_hs_c    = s_axis_tvalid && s_ready_c;

  // Next-state: load on input handshake, step idx on output handshake.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    idx_d   = idx_q;
    load_c  = 1'b0;
`ifdef AXIS_OUT_DOWNSIZER_SKIP_NULL_EN
    last_idx_d = last_idx_q;
`endif

    case (state_q)
      ST_EMPTY: begin
        if (s_hs_c) load_c = 1'b1;
      end
      ST_FULL: begin
        if (m_hs_c) begin
          if (!at_last_c) begin
            idx_d = idx_q + SEL_W'(1);
          end else if (s_hs_c) begin
            load_c = 1'b1;
          end else begin
            state_d = ST_EMPTY;
            idx_d   = '0;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (load_c) begin
      data_d  = s_axis_tdata;
      keep_d  = s_axis_tkeep;
      last_d  = s_axis_tlast;
      idx_d   = '0;
      state_d = ST_FULL;
`ifdef AXIS_OUT_DOWNSIZER_SKIP_NULL_EN
      last_idx_d = load_any_c ? load_last_idx_c : '0;
      // A keep-less beat that does not close a packet carries nothing.
      if (!load_any_c && !s_axis_tlast) state_d = ST_EMPTY;
`endif
    end
  end

  // Control state with synchronous reset; held payload needs none.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_EMPTY;
      idx_q   <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
`ifdef AXIS_OUT_DOWNSIZER_SKIP_NULL_EN
      last_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
`ifdef AXIS_OUT_DOWNSIZER_SKIP_NULL_EN
      last_idx_q <= last_idx_d;
`endif
    end
  end

  // Held wide-beat data register.
  always_ff @(posedge aclk) begin
    data_q <= data_d;
  end

  axis_out_slice_mux #(
    .WORD_WIDTH (WORD_WIDTH),
    .S_WORDS    (S_WORDS),
    .M_WORDS    (M_WORDS),
    .SEL_W      (SEL_W)
  ) u_slice_mux (
    .hold_data (data_q),
    .hold_keep (keep_q),
    .idx       (idx_q),
    .tdata_c   (m_axis_tdata),
    .tkeep_c   (m_axis_tkeep)
  );

  assign s_axis_tready = s_ready_c;
  assign m_axis_tvalid = (state_q == ST_FULL);
  assign m_axis_tlast  = last_q && at_last_c;

endmodule

// File: tb/tb_axis_out_downsizer.sv
// Scoreboard bench for axis_out_downsizer (8->2 words) plus an 8->4 instance.
module tb_axis_out_downsizer;
  import axis_out_pkg::*;

  localparam int unsigned WW = 32;
  localparam int unsigned SW = 8;
  localparam int unsigned MW = 2;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic                 s_axis_tvalid = 1'b0;
  logic                 s_axis_tready;
  logic [SW*WW-1:0]     s_axis_tdata = '0;
  logic [SW-1:0]        s_axis_tkeep = '0;
  logic                 s_axis_tlast = 1'b0;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready = 1'b1;
  logic [MW*WW-1:0]     m_axis_tdata;
  logic [MW-1:0]        m_axis_tkeep;
  logic                 m_axis_tlast;

  logic                 s2_tvalid = 1'b0;
  logic                 s2_tready;
  logic [SW*WW-1:0]     s2_tdata = '0;
  logic [SW-1:0]        s2_tkeep = '0;
  logic                 s2_tlast = 1'b0;
  logic                 m2_tvalid;
  logic                 m2_tready = 1'b1;
  logic [4*WW-1:0]      m2_tdata;
  logic [3:0]           m2_tkeep;
  logic                 m2_tlast;

  axis_out_downsizer #(.WORD_WIDTH(WW), .S_WORDS(SW), .M_WORDS(MW)) u_dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast)
  );

  axis_out_downsizer #(.WORD_WIDTH(WW), .S_WORDS(SW), .M_WORDS(4)) u_dut4 (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s2_tvalid), .s_axis_tready(s2_tready),
    .s_axis_tdata(s2_tdata), .s_axis_tkeep(s2_tkeep), .s_axis_tlast(s2_tlast),
    .m_axis_tvalid(m2_tvalid), .m_axis_tready(m2_tready),
    .m_axis_tdata(m2_tdata), .m_axis_tkeep(m2_tkeep), .m_axis_tlast(m2_tlast)
  );

  typedef struct {
    logic [MW*WW-1:0] data;
    logic [MW-1:0]    keep;
    logic             last;
  } exp_t;

  exp_t sb_q[$];
  int   in_cyc_q[$];
  int   out_cyc_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   out_cnt = 0;
  bit   rnd_en = 1'b0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected narrow beats for one accepted wide beat.
  function automatic void push_beat(input logic [SW*WW-1:0] d, input logic [SW-1:0] k,
                                    input logic l);
    int   n;
    exp_t e;
`ifdef AXIS_OUT_DOWNSIZER_SKIP_NULL_EN
    int hi = -1;
    for (int j = 0; j < int'(RATIO); j++)
      if (k[j*MW +: MW] != '0) hi = j;
    n = (hi < 0) ? (l ? 1 : 0) : hi + 1;
`else
    n = int'(RATIO);
`endif
    for (int j = 0; j < n; j++) begin
      e.data = d[j*MW*WW +: MW*WW];
      e.keep = k[j*MW +: MW];
      e.last = l && (j == n - 1);
      sb_q.push_back(e);
    end
  endfunction

  function automatic logic [SW*WW-1:0] make_data(input int base);
    logic [SW*WW-1:0] r;
    for (int i = 0; i < int'(SW); i++) r[i*WW +: WW] = WW'(base + i);
    return r;
  endfunction

  // Monitor: scoreboard pushes/pops and AXIS hold-stable checks.
  logic             stall = 1'b0;
  logic [MW*WW-1:0] st_data;
  logic [MW-1:0]    st_keep;
  logic             st_last;
  exp_t             mon_e;
  always @(negedge aclk) begin
    if (!areset) begin
      if (stall) begin
        check("hold_valid", 128'(m_axis_tvalid), 128'(1));
        check("hold_data", 128'(m_axis_tdata), 128'(st_data));
        check("hold_keep", 128'(m_axis_tkeep), 128'(st_keep));
        check("hold_last", 128'(m_axis_tlast), 128'(st_last));
      end
      if (s_axis_tvalid && s_axis_tready) begin
        push_beat(s_axis_tdata, s_axis_tkeep, s_axis_tlast);
        in_cyc_q.push_back(cyc);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        out_cnt++;
        out_cyc_q.push_back(cyc);
        if (sb_q.size() == 0) begin
          check("sb_unexpected_beat", 128'(1), 128'(0));
        end else begin
          mon_e = sb_q.pop_front();
          check("out_data", 128'(m_axis_tdata), 128'(mon_e.data));
          check("out_keep", 128'(m_axis_tkeep), 128'(mon_e.keep));
          check("out_last", 128'(m_axis_tlast), 128'(mon_e.last));
        end
      end
      stall   = m_axis_tvalid && !m_axis_tready;
      st_data = m_axis_tdata;
      st_keep = m_axis_tkeep;
      st_last = m_axis_tlast;
    end else begin
      stall = 1'b0;
    end
  end

  // Random downstream backpressure when enabled.
  initial forever begin
    @(posedge aclk);
    #1;
    if (rnd_en) m_axis_tready = ($urandom_range(0, 99) < 20);
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input logic [SW*WW-1:0] d, input logic [SW-1:0] k, input logic l);
    int t = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    @(negedge aclk);
    while (!s_axis_tready && t < 1000) begin
      @(negedge aclk);
      t++;
    end
    if (!s_axis_tready) check("s_accept_timeout", 128'(0), 128'(1));
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb_q.size() != 0 || m_axis_tvalid) && t < 2000) begin
      @(posedge aclk);
      #1;
      t++;
    end
    check("drain", 128'(sb_q.size() == 0 && !m_axis_tvalid), 128'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int        c0;
    int        k;
    int        t;
    logic [127:0] exp4 [2];

    // Reset state
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_m_valid", 128'(m_axis_tvalid), 128'(0));
    check("rst_m_last", 128'(m_axis_tlast), 128'(0));
    check("rst_m_keep", 128'(m_axis_tkeep), 128'(0));
    check("rst_s_ready", 128'(s_axis_tready), 128'(0));
    check("rst_m2_valid", 128'(m2_tvalid), 128'(0));
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // Single beat: 4 sub-beats, one cycle latency
    c0 = out_cnt;
    send_beat(make_data(32'h10), 8'hFF, 1'b1);
    @(negedge aclk);
    check("t1_latency", 128'(m_axis_tvalid), 128'(1));
    check("t1_first_data", 128'(m_axis_tdata), 128'(64'h0000_0011_0000_0010));
    @(posedge aclk);
    #1;
    wait_drain();
    check("t1_count", 128'(out_cnt - c0), 128'(4));

    // Back-to-back beats: no output bubbles, input accepted every 4 cycles
    in_cyc_q.delete();
    out_cyc_q.delete();
    for (int b = 0; b < 3; b++) send_beat(make_data(32'h20 + 8 * b), 8'hFF, b == 2);
    wait_drain();
    check("t2_in_count", 128'(in_cyc_q.size()), 128'(3));
    check("t2_out_count", 128'(out_cyc_q.size()), 128'(12));
    if (in_cyc_q.size() == 3 && out_cyc_q.size() == 12) begin
      check("t2_in_gap0", 128'(in_cyc_q[1] - in_cyc_q[0]), 128'(4));
      check("t2_in_gap1", 128'(in_cyc_q[2] - in_cyc_q[1]), 128'(4));
      check("t2_out_span", 128'(out_cyc_q[11] - out_cyc_q[0]), 128'(11));
      check("t2_latency", 128'(out_cyc_q[0] - in_cyc_q[0]), 128'(1));
    end

    // Random backpressure with random payloads
    rnd_en = 1'b1;
    for (int b = 0; b < 8; b++)
      send_beat({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                8'($urandom), 1'($urandom));
    send_beat(make_data(32'h30), 8'hFF, 1'b1);
    wait_drain();
    rnd_en = 1'b0;
    m_axis_tready = 1'b1;
    @(posedge aclk);
    #1;

    // Partial keep
    c0 = out_cnt;
    send_beat(make_data(32'h40), 8'h0F, 1'b1);
    wait_drain();
`ifdef AXIS_OUT_DOWNSIZER_SKIP_NULL_EN
    check("t4_count", 128'(out_cnt - c0), 128'(2));
`else
    check("t4_count", 128'(out_cnt - c0), 128'(4));
`endif

    // Reset mid-packet after two sub-beats
    c0 = out_cnt;
    send_beat(make_data(32'h50), 8'hFF, 1'b1);
    t = 0;
    while (out_cnt - c0 < 2 && t < 100) begin
      @(posedge aclk);
      #1;
      t++;
    end
    check("t5_two_out", 128'(out_cnt - c0), 128'(2));
    areset = 1'b1;
    m_axis_tready = 1'b0;
    @(negedge aclk);
    check("t5_s_ready_in_rst", 128'(s_axis_tready), 128'(0));
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check("t5_m_valid_after", 128'(m_axis_tvalid), 128'(0));
    check("t5_s_ready_after", 128'(s_axis_tready), 128'(1));
    sb_q.delete();
    @(posedge aclk);
    #1;
    m_axis_tready = 1'b1;
    @(negedge aclk);
    check("t5_no_partial", 128'(m_axis_tvalid), 128'(0));
    @(posedge aclk);
    #1;
    c0 = out_cnt;
    send_beat(make_data(32'h60), 8'hFF, 1'b1);
    wait_drain();
    check("t5_next_count", 128'(out_cnt - c0), 128'(4));

    // 8->4 instance
    exp4[0] = {32'h13, 32'h12, 32'h11, 32'h10};
    exp4[1] = {32'h17, 32'h16, 32'h15, 32'h14};
    s2_tvalid = 1'b1;
    s2_tdata  = make_data(32'h10);
    s2_tkeep  = 8'hFF;
    s2_tlast  = 1'b1;
    @(negedge aclk);
    check("t6_s_ready", 128'(s2_tready), 128'(1));
    @(posedge aclk);
    #1;
    s2_tvalid = 1'b0;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      if (m2_tvalid && m2_tready) begin
        if (k == 0) check("t6_latency", 128'(c), 128'(0));
        if (k < 2) begin
          check("t6_data", m2_tdata, exp4[k]);
          check("t6_keep", 128'(m2_tkeep), 128'(4'hF));
          check("t6_last", 128'(m2_tlast), 128'(k == 1));
        end
        k++;
      end
    end
    check("t6_count", 128'(k), 128'(2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
